program_memory_loader: RTL

- Upstream write-master for the 64K x 32 on-chip program memory (single-port, byte-enabled, one-cycle read latency).
- Receives a framed byte stream from a UART/JTAG byte source, assembles little-endian 32-bit words and writes them into the memory port.
- Holds the processor's reset_req asserted while a load is in flight, then releases it so the CPU boots the new image.

---
 rtl/program_memory_loader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/program_memory_loader.sv
// program_memory_loader: framed byte stream -> 32-bit program memory writes.
// Optional read-back check of every word: define PROGRAM_MEMORY_LOADER_VERIFY_EN.
module program_memory_loader #(
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic              cpu_reset_req,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_FAIL, S_VERIFY, S_VCMP
   } state_t;

   localparam logic [31:0]       TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
   localparam logic              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic                r_rdy;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_maddr;
   logic [15:0]         r_cnt;
   logic [7:0]          r_alo;
   logic [7:0]          r_sum;
   logic [1:0]          r_bcnt;
   logic [31:0]         r_word;
   logic [31:0]         r_wdata;
   logic [31:0]         r_to;
   logic                r_cs;
   logic                r_we;
   logic                r_rreq;
   logic                r_done;
   logic                r_err;

   logic                w_xfer;
   logic                w_to_hit;
   logic                w_last;
   logic [7:0]          w_sum_nxt;
   logic [31:0]         w_word_nxt;

   assign w_xfer     = in_valid & r_rdy;
   assign w_to_hit   = TO_EN && (r_to == TO_LAST);
   assign w_last     = (r_cnt == 16'd1);
   assign w_sum_nxt  = r_sum + in_data;
   assign w_word_nxt = {in_data, r_word[31:8]};

`ifndef PROGRAM_MEMORY_LOADER_VERIFY_EN
   logic w_unused;
   assign w_unused = ^mem_readdata;
`endif

   assign in_ready       = r_rdy;
   assign mem_address    = r_maddr;
   assign mem_byteenable = 4'hF;
   assign mem_chipselect = r_cs;
   assign mem_write      = r_we;
   assign mem_writedata  = r_wdata;
   assign cpu_reset_req  = r_rreq;
   assign load_done      = r_done;
   assign load_error     = r_err;

   // Frame parser, memory write sequencer and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_rdy   <= 1'b0;
         r_addr  <= '0;
         r_maddr <= '0;
         r_cnt   <= '0;
         r_alo   <= '0;
         r_sum   <= '0;
         r_bcnt  <= '0;
         r_word  <= '0;
         r_wdata <= '0;
         r_to    <= '0;
         r_cs    <= 1'b0;
         r_we    <= 1'b0;
         r_rreq  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rdy <= 1'b1;
               if (w_xfer && in_data == 8'hA5) begin
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_rreq  <= 1'b1;
                  r_sum   <= '0;
                  r_bcnt  <= '0;
                  r_to    <= '0;
                  r_state <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_to   <= '0;
                  r_sum  <= w_sum_nxt;
                  r_bcnt <= r_bcnt + 2'd1;
                  case (r_bcnt)
                     2'd0: r_alo <= in_data;
                     2'd1: r_addr <= ADDR_W'({in_data, r_alo});
                     2'd2: r_cnt[7:0] <= in_data;
                     default: begin
                        r_cnt[15:8] <= in_data;
                        if ({in_data, r_cnt[7:0]} == 16'd0)
                           r_state <= S_CHK;
                        else
                           r_state <= S_DATA;
                     end
                  endcase
               end else if (w_to_hit) begin
                  r_rdy   <= 1'b0;
                  r_state <= S_FAIL;
               end else begin
                  r_to <= r_to + 32'd1;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_to   <= '0;
                  r_sum  <= w_sum_nxt;
                  r_word <= w_word_nxt;
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_rdy   <= 1'b0;
                     r_cs    <= 1'b1;
                     r_we    <= 1'b1;
                     r_maddr <= r_addr;
                     r_wdata <= w_word_nxt;
                     r_state <= S_WRITE;
                  end
               end else if (w_to_hit) begin
                  r_rdy   <= 1'b0;
                  r_state <= S_FAIL;
               end else begin
                  r_to <= r_to + 32'd1;
               end
            end
            S_WRITE: begin
               if (!mem_waitrequest) begin
                  r_we <= 1'b0;
`ifdef PROGRAM_MEMORY_LOADER_VERIFY_EN
                  r_state <= S_VERIFY;
`else
                  r_cs    <= 1'b0;
                  r_addr  <= r_addr + A_ONE;
                  r_cnt   <= r_cnt - 16'd1;
                  r_to    <= '0;
                  r_rdy   <= 1'b1;
                  r_state <= w_last ? S_CHK : S_DATA;
`endif
               end
            end
`ifdef PROGRAM_MEMORY_LOADER_VERIFY_EN
            S_VERIFY: begin
               if (!mem_waitrequest) begin
                  r_cs    <= 1'b0;
                  r_state <= S_VCMP;
               end
            end
            S_VCMP: begin
               if (mem_readdata != r_wdata) begin
                  r_state <= S_FAIL;
               end else begin
                  r_addr  <= r_addr + A_ONE;
                  r_cnt   <= r_cnt - 16'd1;
                  r_to    <= '0;
                  r_rdy   <= 1'b1;
                  r_state <= w_last ? S_CHK : S_DATA;
               end
            end
`endif
            S_CHK: begin
               if (w_xfer) begin
                  r_to <= '0;
                  if (in_data == r_sum) begin
                     r_done  <= 1'b1;
                     r_rreq  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_rdy   <= 1'b0;
                     r_state <= S_FAIL;
                  end
               end else if (w_to_hit) begin
                  r_rdy   <= 1'b0;
                  r_state <= S_FAIL;
               end else begin
                  r_to <= r_to + 32'd1;
               end
            end
            S_FAIL: begin
               r_err   <= 1'b1;
               r_rdy   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_rdy   <= 1'b1;
               r_cs    <= 1'b0;
               r_we    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
